// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory interface types used across the multicore design.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Handshake state returned by the RAM to the coherence controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_latency_pkg.sv
// Local types for the programmable-latency RAM controller.
package ram_latency_pkg;
  import cpu_types_pkg::*;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } fsm_state_t;

  // Everything the requester drives; any change to it while waiting restarts the latency.
  typedef struct packed {
    word_t addr;
    word_t store;
    logic  ren;
    logic  wen;
  } mem_req_t;

  // Wait-counter start value; a zero latency never enters WAIT, so it reloads to zero.
  function automatic logic [CNT_W-1:0] cnt_reload(input int lat);
    return (lat > 0) ? CNT_W'(lat - 1) : '0;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Word-wide storage with one write port (request path over loader path) and one
// asynchronous read port.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  word_t             req_data,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  word_t             init_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output word_t             rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  word_t             mem_q [DEPTH];
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  word_t             wdata_d;

  // Select the write source; a memory request always wins over the loader.
  always_comb begin
    we_d    = req_we | init_we;
    waddr_d = req_we ? req_addr : init_addr;
    wdata_d = req_we ? req_data : init_data;
  end

  // Commit the selected write at the clock edge.
  // NOTE: the storage array has no reset on purpose; clearing thousands of words
  // would prevent mapping onto RAM macros, and contents are preloaded instead.
  always_ff @(posedge CLK) begin
    if (we_d) mem_q[waddr_d] <= wdata_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ram_latency_ctrl.sv
// Word-addressed RAM target with programmable access latency, request checking
// and a loader port usable while idle.
module ram_latency_ctrl
  import cpu_types_pkg::*;
  import ram_latency_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int LAT    = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       memaddr,
  input  logic [31:0]       memstore,
  input  logic              memREN,
  input  logic              memWEN,
  output logic [31:0]       ramload,
  output ramstate_t         ramstate,
  input  logic              initWEN,
  input  logic [ADDR_W-1:0] initaddr,
  input  logic [31:0]       initdata
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = cnt_reload(LAT);

  fsm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          snap_q, snap_d;
  mem_req_t          cur_req;
  logic              req_valid, req_err, req_match, take_new;
  logic              acc_we, acc_re, init_we;
  logic [ADDR_W-1:0] word_idx;
  word_t             rd_data;

  // Decode the incoming request and flag malformed ones.
  always_comb begin
    cur_req   = '{addr: memaddr, store: memstore, ren: memREN, wen: memWEN};
    req_valid = memREN | memWEN;
    req_match = (cur_req == snap_q);
    word_idx  = memaddr[ADDR_W+1:2];
    req_err   = req_valid && ((memREN && memWEN) ||
                              (memaddr[1:0] != 2'b00) ||
                              (memaddr[31:ADDR_W+2] != '0));
  end

  // Next-state, latency counter and handshake outputs.
  // NOTE: every output is given a default first so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    ramstate = FREE;
    acc_we   = 1'b0;
    acc_re   = 1'b0;
    init_we  = 1'b0;
    take_new = 1'b0;

    if (!nRST) begin
      // Held in reset: report FREE at once and commit nothing.
      state_d = IDLE;
    end else if (req_err) begin
      ramstate = ERROR;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          take_new = req_valid;
          init_we  = !req_valid && initWEN;
        end
        WAIT: begin
          if (!req_valid) begin
            state_d = IDLE;
          end else if (!req_match) begin
            // Requester changed its mind: restart the full latency.
            snap_d   = cur_req;
            cnt_d    = CNT_RELOAD;
            ramstate = BUSY;
          end else if (cnt_q == '0) begin
            ramstate = ACCESS;
            acc_we   = memWEN;
            acc_re   = memREN;
            state_d  = DONE;
          end else begin
            cnt_d    = cnt_q - 1'b1;
            ramstate = BUSY;
          end
        end
        DONE: begin
          // A still-held request was already served; a different one starts fresh.
          if (!req_valid)      state_d  = IDLE;
          else if (!req_match) take_new = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (take_new) begin
        snap_d = cur_req;
        if (LAT == 0) begin
          ramstate = ACCESS;
          acc_we   = memWEN;
          acc_re   = memREN;
          state_d  = DONE;
        end else begin
          cnt_d    = CNT_RELOAD;
          ramstate = BUSY;
          state_d  = WAIT;
        end
      end
    end
  end

  // FSM, counter and request snapshot registers.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  assign ramload = acc_re ? rd_data : '0;

  ram_array #(
    .ADDR_W(ADDR_W)
  ) u_ram_array (
    .CLK      (CLK),
    .req_we   (acc_we),
    .req_addr (word_idx),
    .req_data (memstore),
    .init_we  (init_we),
    .init_addr(initaddr),
    .init_data(initdata),
    .rd_addr  (word_idx),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_ram_latency_ctrl.sv
// Bench for ram_latency_ctrl: four instances at latencies 0, 2, 3 and 4 driven
// independently and checked against a timing/memory reference model.
module tb_ram_latency_ctrl;
  import cpu_types_pkg::*;

  localparam int ADDR_W = 14;
  localparam int N      = 4;
  localparam int LATS [N] = '{0, 2, 3, 4};

  logic              CLK  = 1'b0;
  logic              nRST = 1'b0;
  logic [31:0]       memaddr  [N];
  logic [31:0]       memstore [N];
  logic              memREN   [N];
  logic              memWEN   [N];
  logic              initWEN  [N];
  logic [ADDR_W-1:0] initaddr [N];
  logic [31:0]       initdata [N];
  logic [31:0]       ramload  [N];
  ramstate_t         ramstate [N];

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t ref_mem [int];

  always #5 CLK = ~CLK;

  ram_latency_ctrl #(.ADDR_W(ADDR_W), .LAT(0)) u_lat0 (
    .CLK(CLK), .nRST(nRST), .memaddr(memaddr[0]), .memstore(memstore[0]),
    .memREN(memREN[0]), .memWEN(memWEN[0]), .ramload(ramload[0]), .ramstate(ramstate[0]),
    .initWEN(initWEN[0]), .initaddr(initaddr[0]), .initdata(initdata[0]));
  ram_latency_ctrl #(.ADDR_W(ADDR_W), .LAT(2)) u_lat2 (
    .CLK(CLK), .nRST(nRST), .memaddr(memaddr[1]), .memstore(memstore[1]),
    .memREN(memREN[1]), .memWEN(memWEN[1]), .ramload(ramload[1]), .ramstate(ramstate[1]),
    .initWEN(initWEN[1]), .initaddr(initaddr[1]), .initdata(initdata[1]));
  ram_latency_ctrl #(.ADDR_W(ADDR_W), .LAT(3)) u_lat3 (
    .CLK(CLK), .nRST(nRST), .memaddr(memaddr[2]), .memstore(memstore[2]),
    .memREN(memREN[2]), .memWEN(memWEN[2]), .ramload(ramload[2]), .ramstate(ramstate[2]),
    .initWEN(initWEN[2]), .initaddr(initaddr[2]), .initdata(initdata[2]));
  ram_latency_ctrl #(.ADDR_W(ADDR_W), .LAT(4)) u_lat4 (
    .CLK(CLK), .nRST(nRST), .memaddr(memaddr[3]), .memstore(memstore[3]),
    .memREN(memREN[3]), .memWEN(memWEN[3]), .ramload(ramload[3]), .ramstate(ramstate[3]),
    .initWEN(initWEN[3]), .initaddr(initaddr[3]), .initdata(initdata[3]));

  function automatic int key(input int k, input int w);
    return k * 65536 + w;
  endfunction

  task automatic clear_inputs(input int k);
    memaddr[k]  = '0;
    memstore[k] = '0;
    memREN[k]   = 1'b0;
    memWEN[k]   = 1'b0;
    initWEN[k]  = 1'b0;
    initaddr[k] = '0;
    initdata[k] = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Held request: BUSY for LAT cycles, ACCESS on cycle LAT+1, then (tail) FREE
  // while held and FREE after the drop.
  task automatic do_access(input int k, input bit ren, input word_t addr,
                           input word_t data, input bit tail, input string tag);
    int        lat = LATS[k];
    int        w   = int'(addr[ADDR_W+1:2]);
    word_t     exp_load;
    word_t     exp_ld;
    ramstate_t exp_st;
    memREN[k]   = ren;
    memWEN[k]   = !ren;
    memaddr[k]  = addr;
    memstore[k] = data;
    exp_load    = ren ? ref_mem[key(k, w)] : '0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge CLK);
      exp_st = (c <= lat) ? BUSY : ACCESS;
      exp_ld = (c == lat + 1) ? exp_load : '0;
      n_tests++;
      if (ramstate[k] !== exp_st || ramload[k] !== exp_ld) begin
        n_fail++;
        $display("FAIL %s: lat%0d cycle %0d got state=%0d load=%h, expected state=%0d load=%h",
                 tag, lat, c, ramstate[k], ramload[k], exp_st, exp_ld);
      end
      next_cycle();
    end
    if (!ren) ref_mem[key(k, w)] = data;
    if (tail) begin
      @(negedge CLK);
      n_tests++;
      if (ramstate[k] !== FREE || ramload[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL %s_held: lat%0d got state=%0d load=%h, expected state=0 load=0",
                 tag, lat, ramstate[k], ramload[k]);
      end
      next_cycle();
      clear_inputs(k);
      @(negedge CLK);
      n_tests++;
      if (ramstate[k] !== FREE || ramload[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL %s_drop: lat%0d got state=%0d load=%h, expected state=0 load=0",
                 tag, lat, ramstate[k], ramload[k]);
      end
      next_cycle();
    end
  endtask

  // Malformed request: ERROR in the same cycle, ramload 0, then dropped.
  task automatic do_error(input int k, input bit ren, input bit wen, input word_t addr,
                          input string tag);
    memREN[k]   = ren;
    memWEN[k]   = wen;
    memaddr[k]  = addr;
    memstore[k] = 32'hBAD0_BAD0;
    @(negedge CLK);
    n_tests++;
    if (ramstate[k] !== ERROR || ramload[k] !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: got state=%0d load=%h, expected state=3 load=0",
               tag, ramstate[k], ramload[k]);
    end
    next_cycle();
    clear_inputs(k);
    next_cycle();
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      clear_inputs(k);
      memREN[k]  = 1'b1;
      memaddr[k] = 32'h10;
    end
    @(negedge CLK);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (ramstate[k] !== FREE || ramload[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state: inst %0d got state=%0d load=%h, expected state=0 load=0",
                 k, ramstate[k], ramload[k]);
      end
    end
    for (int k = 0; k < N; k++) clear_inputs(k);
    next_cycle();
    nRST = 1'b1;
    next_cycle();
  endtask

  task automatic preload();
    for (int w = 0; w < 32; w++) begin
      for (int k = 0; k < N; k++) begin
        initWEN[k]  = 1'b1;
        initaddr[k] = ADDR_W'(w);
        initdata[k] = (w == 4) ? 32'hDEAD_BEEF : $urandom;
        ref_mem[key(k, w)] = initdata[k];
      end
      next_cycle();
    end
    for (int k = 0; k < N; k++) clear_inputs(k);
  endtask

  task automatic test_read_lat2();
    do_access(1, 1'b1, 32'h10, '0, 1'b1, "read_lat2");
  endtask

  task automatic test_write_lat2();
    do_access(1, 1'b0, 32'h20, 32'h1234_5678, 1'b1, "write_lat2");
    do_access(1, 1'b1, 32'h20, '0, 1'b1, "readback_lat2");
    do_access(1, 1'b1, 32'h24, '0, 1'b1, "neighbour_lat2");
  endtask

  task automatic test_restart_lat3();
    memREN[2]  = 1'b1;
    memaddr[2] = 32'h10;
    @(negedge CLK);
    n_tests++;
    if (ramstate[2] !== BUSY) begin
      n_fail++;
      $display("FAIL restart_first: got state=%0d, expected state=1", ramstate[2]);
    end
    next_cycle();
    do_access(2, 1'b1, 32'h14, '0, 1'b1, "restart_lat3");
  endtask

  task automatic test_errors();
    do_error(1, 1'b1, 1'b1, 32'h10, "err_both");
    do_error(1, 1'b1, 1'b0, 32'h13, "err_misaligned_rd");
    do_error(1, 1'b0, 1'b1, 32'h12, "err_misaligned_wr");
    do_error(1, 1'b1, 1'b0, 32'h0010_0000, "err_range_rd");
    do_error(1, 1'b0, 1'b1, 32'h8000_0000, "err_range_wr");
    // Error arriving mid-wait aborts the pending access.
    memREN[1]  = 1'b1;
    memaddr[1] = 32'h10;
    next_cycle();
    do_error(1, 1'b1, 1'b0, 32'h11, "err_mid_wait");
    do_access(1, 1'b1, 32'h10, '0, 1'b1, "after_err_w4");
    do_access(1, 1'b1, 32'h0, '0, 1'b1, "after_err_w0");
  endtask

  task automatic test_lat0();
    do_access(0, 1'b1, 32'h10, '0, 1'b1, "read_lat0");
    do_access(0, 1'b0, 32'h18, 32'h0BAD_CAFE, 1'b1, "write_lat0");
    do_access(0, 1'b1, 32'h18, '0, 1'b1, "readback_lat0");
  endtask

  task automatic test_back_to_back();
    do_access(1, 1'b0, 32'h40, 32'hA5A5_0001, 1'b0, "b2b_write_lat2");
    do_access(1, 1'b1, 32'h40, '0, 1'b1, "b2b_read_lat2");
    do_access(0, 1'b0, 32'h40, 32'h5A5A_0002, 1'b0, "b2b_write_lat0");
    do_access(0, 1'b1, 32'h40, '0, 1'b1, "b2b_read_lat0");
  endtask

  task automatic test_init_guard();
    initWEN[1]  = 1'b1;
    initaddr[1] = ADDR_W'(4);
    initdata[1] = 32'h1111_2222;
    do_access(1, 1'b1, 32'h10, '0, 1'b0, "init_guard_rd");
    initWEN[1]  = 1'b0;
    clear_inputs(1);
    next_cycle();
    do_access(1, 1'b1, 32'h10, '0, 1'b1, "init_guard_chk");
  endtask

  task automatic test_reset_mid_wait();
    memWEN[3]   = 1'b1;
    memaddr[3]  = 32'h30;
    memstore[3] = 32'hCAFE_F00D;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      n_tests++;
      if (ramstate[3] !== BUSY) begin
        n_fail++;
        $display("FAIL rst_wait_busy: cycle %0d got state=%0d, expected state=1", c, ramstate[3]);
      end
      if (c < 4) next_cycle();
    end
    #1 nRST = 1'b0;
    #1;
    n_tests++;
    if (ramstate[3] !== FREE || ramload[3] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: got state=%0d load=%h, expected state=0 load=0",
               ramstate[3], ramload[3]);
    end
    next_cycle();
    clear_inputs(3);
    nRST = 1'b1;
    next_cycle();
    do_access(3, 1'b1, 32'h30, '0, 1'b1, "rst_target_lat4");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int    k = int'($urandom_range(0, N - 1));
      int    w = int'($urandom_range(0, 31));
      int    r = int'($urandom_range(0, 9));
      word_t a = word_t'(w) << 2;
      if (r == 0) begin
        do_error(k, 1'b1, 1'b0, a | word_t'($urandom_range(1, 3)), "rnd_err");
      end else if (r < 3) begin
        do_access(k, $urandom_range(0, 1) == 1, a, $urandom, 1'b0, "rnd_chain_a");
        do_access(k, $urandom_range(0, 1) == 1, a ^ 32'h4, $urandom, 1'b1, "rnd_chain_b");
      end else begin
        do_access(k, r < 7, a, $urandom, 1'b1, "rnd_single");
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) clear_inputs(k);
    test_reset();
    preload();
    test_read_lat2();
    test_write_lat2();
    test_restart_lat3();
    test_errors();
    test_lat0();
    test_back_to_back();
    test_init_guard();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_latency_ctrl.md
Name: ram_latency_ctrl

Overview:
- Memory-side target of the multicore top's RAM port. It consumes memaddr/memstore/memREN/memWEN from the coherence controller and returns ramload/ramstate.
- Models a word-addressed synchronous RAM with a programmable access latency.
- Provides a testbench/loader init port for preloading the array while held idle.
- Replaces the fixed-latency behavioural RAM so the coherence controller can be exercised under varied memory timing.

Parameters:
- ADDR_W, 14, word-index width; array depth = 2**ADDR_W words of 32 bits.
- LAT, 2, wait cycles before ACCESS (0..15).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- memaddr  input  32  byte address from the coherence controller.
- memstore  input  32  write data.
- memREN  input  1  read request.
- memWEN  input  1  write request.
- ramload  output  32  read data.
- ramstate  output  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- initWEN  input  1  loader write strobe; honoured only in state IDLE.
- initaddr  input  ADDR_W  loader word index.
- initdata  input  32  loader data.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values:
  - FSM = IDLE, wait counter = 0, request snapshot = 0.
  - ramstate = FREE, ramload = 0.
  - Array contents are not reset.
- Request valid: memREN | memWEN.
- Word index: memaddr[ADDR_W+1:2].
- Error conditions (ramstate = ERROR, combinational, same cycle):
  - memREN & memWEN both high.
  - memaddr[1:0] != 0 with a request active.
  - memaddr[31:ADDR_W+2] != 0 with a request active.
  - No array write occurs, the FSM returns to IDLE, and ramload = 0.
- FSM states IDLE, WAIT, DONE:
  - IDLE: ramstate = FREE when there is no request.
    - On a valid non-error request with LAT>0: snapshot {addr, store, REN, WEN}, counter = LAT-1, go to WAIT, ramstate = BUSY this cycle.
    - With LAT==0: ramstate = ACCESS in the same cycle. A write commits at that edge; read data drives ramload combinationally. Go to DONE.
  - WAIT: ramstate = BUSY.
    - Counter decrements each cycle.
    - When counter==0 and the inputs still match the snapshot: ramstate = ACCESS, write commits at this edge, ramload = array[index] combinationally, go to DONE.
  - DONE: one-cycle turnaround.
    - If the request inputs are unchanged (requester has not yet dropped), ramstate = FREE and no second access occurs.
    - If a different valid request is present, treat it as a fresh IDLE request in this cycle.
    - Otherwise go to IDLE.
- Request change mid-wait: any change of addr/store/REN/WEN versus the snapshot while in WAIT restarts the latency. The new snapshot is taken, counter = LAT-1, and ramstate stays BUSY. If the request drops to none, go to IDLE and ramstate = FREE.
- ACCESS latency: exactly LAT+1 cycles from request assertion, counting the assertion cycle as cycle 1. ACCESS is asserted for exactly one cycle per accepted request.
- ramload outside ACCESS-on-read is 0.
- initWEN: writes array[initaddr] = initdata at the edge, only while in IDLE with no request. It is ignored otherwise, and memory requests take priority.
- Reset mid-WAIT: FSM returns to IDLE, no write is committed, ramstate = FREE immediately, asynchronously.
- Write/read same word back-to-back: a read issued the cycle after a write's ACCESS returns the new data.

Decomposition:
- Shared types: ramstate_t and word_t in the existing cpu_types_pkg.
- Local FSM enum {IDLE, WAIT, DONE} stays in a ram_latency_pkg.
- Natural sub-module: ram_array, a single-write-port, one asynchronous-read-port 32-bit storage array with write-enable mux between the request path and the init path. The FSM and counter live in the top.

Test Plan:
- LAT=2, init array[4]=32'hDEADBEEF. Read memaddr=0x10 held: ramstate BUSY, BUSY, ACCESS with ramload=DEADBEEF, then FREE while held.
- LAT=2, write memaddr=0x20 data 0x12345678 held three cycles. Next read at 0x20 gets ACCESS on cycle 3 with 0x12345678. Read at 0x24 returns its old (init) value.
- LAT=3, read 0x10. After 1 cycle, switch memaddr to 0x14: BUSY continues for 3 more cycles from the switch, then ACCESS returns array[5].
- memREN=memWEN=1 at 0x10 -> ERROR the same cycle, array[4] unchanged. memaddr=0x13 read -> ERROR. memaddr=0x0010_0000 with ADDR_W=14 -> ERROR.
- LAT=0, read 0x10 -> ACCESS in the first cycle with data. Following held cycle -> FREE.
- LAT=4 write in progress, pulse nRST low at the WAIT counter=1 cycle -> ramstate FREE at once, target word unchanged, and the next request sees full latency.
